// File: rtl/mem_seq_pkg.sv
// ----------------------------------------------------------------------------
// mem_seq_pkg
//   Shared definitions for the MemX/MemY vector-add sequencer:
//   default widths/latency and the sequencer state encoding.
// ----------------------------------------------------------------------------
package mem_seq_pkg;

   localparam int DEF_ADDR_W     = 4;
   localparam int DEF_LEN_W      = 5;
   localparam int DEF_MEM_RD_LAT = 1;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      WR,
      DONE
   } seqState_t;

endpackage

// File: rtl/mem_seq_idx_cnt.sv
// ----------------------------------------------------------------------------
// mem_seq_idx_cnt
//   Element index counter for the vector-add sequencer. On load it captures
//   the three base addresses and the job length and restarts the index at 0.
//   It produces the wrapped element addresses base+idx and flags the last
//   element of the job.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset (index only)
//   load               capture bases/length, idx <= 0
//   adv                step to the next element
//   baseX/baseY/baseD  read X, read Y and destination base addresses
//   lenIn              job length
//   addrX/addrY/addrD  base + idx, modulo 2^ADDR_W
//   isLast             idx == len-1
// ----------------------------------------------------------------------------
module mem_seq_idx_cnt
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              adv,
   input  logic [ADDR_W-1:0] baseX,
   input  logic [ADDR_W-1:0] baseY,
   input  logic [ADDR_W-1:0] baseD,
   input  logic [LEN_W-1:0]  lenIn,
   output logic [ADDR_W-1:0] addrX,
   output logic [ADDR_W-1:0] addrY,
   output logic [ADDR_W-1:0] addrD,
   output logic              isLast
);

   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  lenQ;
   logic [ADDR_W-1:0] baseXQ;
   logic [ADDR_W-1:0] baseYQ;
   logic [ADDR_W-1:0] baseDQ;

   // Job parameters are plain data: captured on load, never reset.
   always_ff @(posedge clk) begin
      if (load) begin
         baseXQ <= baseX;
         baseYQ <= baseY;
         baseDQ <= baseD;
         lenQ   <= lenIn;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (load) begin
         idx <= '0;
      end else if (adv) begin
         idx <= idx + 1'b1;
      end
   end

   // Sums are truncated to ADDR_W bits so addresses wrap around the memory.
   assign addrX  = baseXQ + ADDR_W'(idx);
   assign addrY  = baseYQ + ADDR_W'(idx);
   assign addrD  = baseDQ + ADDR_W'(idx);
   assign isLast = (idx == (lenQ - 1'b1));

endmodule

// File: rtl/mem_add_sequencer.sv
// ----------------------------------------------------------------------------
// mem_add_sequencer
//   Sequences the MemX/MemY address generator and adder datapath for block
//   vector-add jobs: for each element i it reads MemX[src_x+i], MemY[src_y+i]
//   and writes the sum to MemX or MemY at dst+i. Tracks datapath overflow
//   per job and supports early abort.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, abort                  job request / early termination
//   src_base_x, src_base_y        first read addresses
//   dst_base, len, dst_sel        first write address, element count, target
//   mem_overflow_in               datapath overflow flag
//   read_addressX/Y               read addresses to the datapath
//   write_addressX/Y              write addresses to the datapath
//   write_X_enable/write_Y_enable result write strobes (never both)
//   busy, done, aborted           job status
//   ovf_sticky, ovf_count         per-job overflow tracking
// ----------------------------------------------------------------------------
module mem_add_sequencer
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int LEN_W      = DEF_LEN_W,
   parameter int MEM_RD_LAT = DEF_MEM_RD_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] src_base_x,
   input  logic [ADDR_W-1:0] src_base_y,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [LEN_W-1:0]  len,
   input  logic              dst_sel,
   input  logic              mem_overflow_in,
   output logic [ADDR_W-1:0] read_addressX,
   output logic [ADDR_W-1:0] read_addressY,
   output logic [ADDR_W-1:0] write_addressX,
   output logic [ADDR_W-1:0] write_addressY,
   output logic              write_X_enable,
   output logic              write_Y_enable,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              ovf_sticky,
   output logic [LEN_W-1:0]  ovf_count
);

   localparam int WAIT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_RD_LAT - 1);

   seqState_t         state;
   seqState_t         nextState;
   logic [WAIT_W-1:0] waitCnt;
   logic              waitDone;
   logic              accept;
   logic              dstSelQ;
   logic              isLast;
   logic              advIdx;
   logic [ADDR_W-1:0] addrX;
   logic [ADDR_W-1:0] addrY;
   logic [ADDR_W-1:0] addrD;

   function automatic logic [LEN_W-1:0] satInc(input logic [LEN_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign accept   = (state == IDLE) && start;
   assign waitDone = (waitCnt == WAIT_LAST);
   assign advIdx   = (state == WR) && !isLast && !abort;
   assign busy     = (state != IDLE);

   mem_seq_idx_cnt #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) uIdxCnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .adv    (advIdx),
      .baseX  (src_base_x),
      .baseY  (src_base_y),
      .baseD  (dst_base),
      .lenIn  (len),
      .addrX  (addrX),
      .addrY  (addrY),
      .addrD  (addrD),
      .isLast (isLast)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Counts the read-latency cycles spent in WAIT for the current element.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt <= '0;
      end else if (state == WAIT) begin
         waitCnt <= waitCnt + 1'b1;
      end else begin
         waitCnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         dstSelQ <= dst_sel;
      end
   end

   // Status flags are cleared by an accepted start and then only accumulate,
   // so they stay readable after done until the next job begins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
         aborted    <= 1'b0;
      end else if (accept) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
         aborted    <= 1'b0;
      end else begin
         if ((state == WR) && mem_overflow_in) begin
            ovf_sticky <= 1'b1;
            ovf_count  <= satInc(ovf_count);
         end
         if (abort && ((state == RD) || (state == WAIT) || (state == WR))) begin
            aborted <= 1'b1;
         end
      end
   end

   always_comb begin
      nextState      = state;
      read_addressX  = '0;
      read_addressY  = '0;
      write_addressX = '0;
      write_addressY = '0;
      write_X_enable = 1'b0;
      write_Y_enable = 1'b0;
      done           = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               nextState = (len == '0) ? DONE : RD;
            end
         end
         RD: begin
            read_addressX = addrX;
            read_addressY = addrY;
            nextState     = abort ? DONE : WAIT;
         end
         WAIT: begin
            read_addressX = addrX;
            read_addressY = addrY;
            if (abort) begin
               nextState = DONE;
            end else if (waitDone) begin
               nextState = WR;
            end
         end
         WR: begin
            // An abort seen here still lets this element's write complete.
            read_addressX  = addrX;
            read_addressY  = addrY;
            write_addressX = addrD;
            write_addressY = addrD;
            write_X_enable = !dstSelQ;
            write_Y_enable = dstSelQ;
            nextState      = (abort || isLast) ? DONE : RD;
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_add_sequencer.sv
module tb_mem_add_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [3:0] src_base_x;
   logic [3:0] src_base_y;
   logic [3:0] dst_base;
   logic [4:0] len;
   logic       dst_sel;
   logic       mem_overflow_in;
   logic [3:0] read_addressX;
   logic [3:0] read_addressY;
   logic [3:0] write_addressX;
   logic [3:0] write_addressY;
   logic       write_X_enable;
   logic       write_Y_enable;
   logic       busy;
   logic       done;
   logic       aborted;
   logic       ovf_sticky;
   logic [4:0] ovf_count;

   int nCmp = 0;
   int nBad = 0;

   always #5 clk = ~clk;

   mem_add_sequencer #(
      .ADDR_W     (4),
      .LEN_W      (5),
      .MEM_RD_LAT (1)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .abort           (abort),
      .src_base_x      (src_base_x),
      .src_base_y      (src_base_y),
      .dst_base        (dst_base),
      .len             (len),
      .dst_sel         (dst_sel),
      .mem_overflow_in (mem_overflow_in),
      .read_addressX   (read_addressX),
      .read_addressY   (read_addressY),
      .write_addressX  (write_addressX),
      .write_addressY  (write_addressY),
      .write_X_enable  (write_X_enable),
      .write_Y_enable  (write_Y_enable),
      .busy            (busy),
      .done            (done),
      .aborted         (aborted),
      .ovf_sticky      (ovf_sticky),
      .ovf_count       (ovf_count)
   );

   task automatic chkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Starts a job, scrambles the inputs right after acceptance, and follows
   // it cycle by cycle until done. Cycle 1 is the cycle after the start edge.
   task automatic runJob(input logic [3:0] sx, input logic [3:0] sy, input logic [3:0] d,
                         input logic [4:0] l, input logic sel, input logic [15:0] ovfMask,
                         input int abortCyc, input int glitchCyc, input int expWr,
                         input int expDone, input int expOvf, input logic expAbort);
      int c;
      int nWr;
      int doneC;
      logic [3:0] eAddr;
      @(negedge clk);
      src_base_x = sx;
      src_base_y = sy;
      dst_base   = d;
      len        = l;
      dst_sel    = sel;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      src_base_x = ~sx;
      src_base_y = ~sy;
      dst_base   = ~d;
      len        = 5'd1;
      dst_sel    = ~sel;
      chkEq("ovfStickyClr", ovf_sticky, 0);
      chkEq("ovfCountClr", ovf_count, 0);
      chkEq("abortedClr", aborted, 0);
      nWr   = 0;
      doneC = 0;
      for (c = 1; c <= 120; c++) begin
         abort           = (c == abortCyc);
         start           = (c == glitchCyc);
         mem_overflow_in = 1'b0;
         if (write_X_enable || write_Y_enable) begin
            chkEq("wrXEn", write_X_enable, !sel);
            chkEq("wrYEn", write_Y_enable, sel);
            chkEq("wrCycle", c, 3 * (nWr + 1));
            eAddr = d + 4'(nWr);
            chkEq("wrAddrX", write_addressX, eAddr);
            chkEq("wrAddrY", write_addressY, eAddr);
            eAddr = sx + 4'(nWr);
            chkEq("rdAddrX", read_addressX, eAddr);
            eAddr = sy + 4'(nWr);
            chkEq("rdAddrY", read_addressY, eAddr);
            if (nWr < 16) mem_overflow_in = ovfMask[nWr];
            nWr++;
         end
         if (done) begin
            doneC = c;
            chkEq("wrEnAtDone", {write_X_enable, write_Y_enable}, 0);
            chkEq("ovfStickyDone", ovf_sticky, (expOvf != 0));
            chkEq("ovfCountDone", ovf_count, expOvf);
            chkEq("abortedDone", aborted, expAbort);
            break;
         end
         chkEq("busyRun", busy, 1);
         @(negedge clk);
      end
      chkEq("doneCycle", doneC, expDone);
      chkEq("writeCount", nWr, expWr);
      // A start presented in DONE must be ignored.
      abort           = 1'b0;
      mem_overflow_in = 1'b0;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chkEq("idleBusy", busy, 0);
      chkEq("donePulse", done, 0);
      chkEq("abortedHold", aborted, expAbort);
   endtask

   initial begin
      rst_n           = 1'b0;
      start           = 1'b0;
      abort           = 1'b0;
      src_base_x      = '0;
      src_base_y      = '0;
      dst_base        = '0;
      len             = '0;
      dst_sel         = 1'b0;
      mem_overflow_in = 1'b0;
      #1;
      chkEq("rstBusy", busy, 0);
      chkEq("rstDone", done, 0);
      chkEq("rstWrEn", {write_X_enable, write_Y_enable}, 0);
      chkEq("rstAddr", {read_addressX, read_addressY, write_addressX, write_addressY}, 0);
      chkEq("rstStatus", {aborted, ovf_sticky, ovf_count}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single element into MemX.
      runJob(4'd0, 4'd0, 4'd0, 5'd1, 1'b0, 16'h0000, 0, 0, 1, 4, 0, 1'b0);
      // Full 16-element job into MemY with wrapping destination.
      runJob(4'd3, 4'd9, 4'd14, 5'd16, 1'b1, 16'h0000, 0, 0, 16, 49, 0, 1'b0);
      // Overflow on elements 2 and 5, then a clean job clears it.
      runJob(4'd1, 4'd2, 4'd4, 5'd8, 1'b0, 16'h0024, 0, 0, 8, 25, 2, 1'b0);
      runJob(4'd5, 4'd6, 4'd7, 5'd2, 1'b1, 16'h0000, 0, 0, 2, 7, 0, 1'b0);
      // Abort in WAIT of element 3 (cycle 11), then in WR of element 3 (cycle 12).
      runJob(4'd0, 4'd8, 4'd12, 5'd8, 1'b1, 16'h0000, 11, 0, 3, 12, 0, 1'b1);
      runJob(4'd2, 4'd3, 4'd15, 5'd8, 1'b0, 16'h0000, 12, 0, 4, 13, 0, 1'b1);
      // Zero-length job, then a start glitch while busy.
      runJob(4'd7, 4'd7, 4'd7, 5'd0, 1'b0, 16'h0000, 0, 0, 0, 1, 0, 1'b0);
      runJob(4'd10, 4'd11, 4'd13, 5'd4, 1'b1, 16'h0000, 0, 5, 4, 13, 0, 1'b0);

      // Reset during the first WR of a len=4 job.
      @(negedge clk);
      src_base_x = 4'd1;
      src_base_y = 4'd2;
      dst_base   = 4'd3;
      len        = 5'd4;
      dst_sel    = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chkEq("preRstWrX", write_X_enable, 1);
      rst_n = 1'b0;
      #1;
      chkEq("rstMidWrEn", {write_X_enable, write_Y_enable}, 0);
      chkEq("rstMidBusy", busy, 0);
      chkEq("rstMidDone", done, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chkEq("rstHoldDone", done, 0);
      end
      rst_n = 1'b1;
      runJob(4'd4, 4'd5, 4'd6, 5'd2, 1'b0, 16'h0001, 0, 0, 2, 7, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
